// File: rtl/isa_bus_pkg.sv
// ============================================================================
// Module : isa_bus_pkg
// Brief  : Shared ISA bus widths and FSM state encodings for the I/O slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package isa_bus_pkg;

  localparam int ISA_ADDR_W = 12;
  localparam int ISA_DATA_W = 16;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_COMMIT = 2'd2
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_DRIVE = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/isa_strobe_sync.sv
// ============================================================================
// Module : isa_strobe_sync
// Brief  : Multi-stage synchroniser and edge detector for an active-low strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module isa_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_n_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   vld_q;

  // Edges are suppressed until the chain holds only post-reset samples, so a
  // strobe already low at reset release never looks like a fresh falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign fall_o  = vld_q[SYNC_STAGES] & prev_q & ~level_o;
  assign rise_o  = vld_q[SYNC_STAGES] & ~prev_q & level_o;

endmodule

`default_nettype wire

// File: rtl/isa_io_register_bank.sv
// ============================================================================
// Module : isa_io_register_bank
// Brief  : Clocked PC/104 I/O slave: NUM_REGS write/readback registers plus a
//          read-only input port. Build with ISA_WDOG_EN for the write watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module isa_io_register_bank
  import isa_bus_pkg::*;
#(
  parameter logic [ISA_ADDR_W-1:0] BASE_ADDR   = 12'h240,
  parameter int                    NUM_REGS    = 4,
  parameter int                    DATA_W      = 8,
  parameter bit                    INVERT      = 1'b1,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [23:0]           WDOG_CYCLES = 24'd8_000_000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         iow_i,
  input  logic                         ior_i,
  input  logic                         aen_i,
  input  logic [ISA_ADDR_W-1:0]        sa_i,
  input  logic [ISA_DATA_W-1:0]        sd_in_i,
  output logic [ISA_DATA_W-1:0]        sd_out_o,
  output logic                         sd_oe_o,
  output logic                         iocs16_oe_o,
  input  logic [DATA_W-1:0]            in_port_i,
  output logic [NUM_REGS*DATA_W-1:0]   out_reg_o,
  output logic [NUM_REGS-1:0]          wr_stb_o
);

  localparam logic [ISA_ADDR_W-1:0] NUM_REGS_A = ISA_ADDR_W'(NUM_REGS);
  localparam logic [DATA_W-1:0]     RST_VAL    = {DATA_W{INVERT}};
  localparam bit                    WIDE       = (DATA_W > 8);

  logic w_iow_lvl, w_iow_fall, w_iow_rise;
  logic w_ior_lvl, w_ior_fall, w_ior_rise;

  isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_iow_sync (
    .clk_i(clk_i), .rst_i(rst_i), .strobe_n_i(iow_i),
    .level_o(w_iow_lvl), .fall_o(w_iow_fall), .rise_o(w_iow_rise)
  );

  isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ior_sync (
    .clk_i(clk_i), .rst_i(rst_i), .strobe_n_i(ior_i),
    .level_o(w_ior_lvl), .fall_o(w_ior_fall), .rise_o(w_ior_rise)
  );

  logic [ISA_ADDR_W-1:0] w_offset;
  logic w_reg_hit, w_port_hit, w_wdog_hit, w_any_port;
  logic w_wdog_fire, wdog_trip_q;

  assign w_offset    = sa_i - BASE_ADDR;
  assign w_reg_hit   = ~aen_i & (w_offset < NUM_REGS_A);
  assign w_port_hit  = ~aen_i & (w_offset == NUM_REGS_A);
  assign w_any_port  = w_port_hit | w_wdog_hit;
  assign iocs16_oe_o = WIDE & (w_reg_hit | w_any_port);

  // ---------------------------------------------------------------- write FSM
  wr_state_e         w_state_q, w_state_d;
  logic [2:0]        off_q, off_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] w_store;
  logic              w_commit;

  always_comb begin
    w_state_d = w_state_q;
    off_d     = off_q;
    hold_d    = hold_q;
    unique case (w_state_q)
      W_IDLE:   if (w_iow_fall && w_reg_hit) w_state_d = W_ACTIVE;
      W_ACTIVE: begin
        off_d  = w_offset[2:0];
        hold_d = sd_in_i[DATA_W-1:0];
        if (aen_i)           w_state_d = W_IDLE;
        else if (w_iow_rise) w_state_d = W_COMMIT;
      end
      W_COMMIT: w_state_d = W_IDLE;
      default:  w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      off_q     <= '0;
      hold_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      off_q     <= off_d;
      hold_q    <= hold_d;
    end
  end

  assign w_commit = (w_state_q == W_COMMIT) && ({{(ISA_ADDR_W-3){1'b0}}, off_q} < NUM_REGS_A);
  assign w_store  = INVERT ? ~hold_q : hold_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (off_q == 3'(i)) regs_q[i] <= w_store;
      end
    end else if (w_wdog_fire) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign out_reg_o[g*DATA_W +: DATA_W] = regs_q[g];
    assign wr_stb_o[g]                   = w_commit && (off_q == 3'(g));
  end

  // ----------------------------------------------------------------- watchdog
`ifdef ISA_WDOG_EN
  logic [23:0] wdog_cnt_q;

  assign w_wdog_hit  = ~aen_i & (w_offset == NUM_REGS_A + 12'd1);
  assign w_wdog_fire = ~w_commit & (wdog_cnt_q == WDOG_CYCLES - 24'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else if (w_commit) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else if (w_wdog_fire) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b1;
    end else begin
      wdog_cnt_q  <= wdog_cnt_q + 24'd1;
    end
  end
`else
  assign w_wdog_hit  = 1'b0;
  assign w_wdog_fire = 1'b0;
  assign wdog_trip_q = 1'b0;
`endif

  // ----------------------------------------------------------------- read FSM
  rd_state_e             r_state_q, r_state_d;
  logic [ISA_DATA_W-1:0] sd_out_q, sd_out_d;
  logic [ISA_DATA_W-1:0] w_rdata;
  logic                  w_r_exit;

  // A concurrent write owns the cycle, so a low IOW also ends any drive.
  assign w_r_exit = w_ior_rise | aen_i | ~w_iow_lvl;

  always_comb begin
    w_rdata = '0;
    if (w_reg_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_offset == ISA_ADDR_W'(i)) w_rdata[DATA_W-1:0] = INVERT ? ~regs_q[i] : regs_q[i];
      end
    end else if (w_port_hit) begin
      w_rdata[DATA_W-1:0] = in_port_i;
    end else if (w_wdog_hit) begin
      w_rdata[0] = wdog_trip_q;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (w_ior_fall && (w_reg_hit || w_any_port) && w_iow_lvl) r_state_d = R_DRIVE;
      R_DRIVE: if (w_r_exit) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    sd_out_d = (r_state_d == R_DRIVE) ? w_rdata : sd_out_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      sd_out_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      sd_out_q  <= sd_out_d;
    end
  end

  assign sd_out_o = sd_out_q;
  assign sd_oe_o  = (r_state_q == R_DRIVE) & ~w_r_exit;

  logic w_unused;
  assign w_unused = ^{sd_in_i, w_ior_lvl, wdog_trip_q};

endmodule

`default_nettype wire

// File: tb/tb_isa_io_register_bank.sv
// ============================================================================
// Module : tb_isa_io_register_bank
// Brief  : Table-driven, directed and randomised checks of the ISA I/O slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_isa_io_register_bank;

  logic        clk = 1'b0;
  logic        rst, iow, ior, aen;
  logic [11:0] sa;
  logic [15:0] sd_in, in_b;
  logic [7:0]  in_a;

  logic [15:0] sd_out_a, sd_out_b;
  logic        oe_a, oe_b, cs_a, cs_b;
  logic [31:0] out_a;
  logic [63:0] out_b;
  logic [3:0]  stb_a, stb_b;

  always #5 clk = ~clk;

  isa_io_register_bank u_a (
    .clk_i(clk), .rst_i(rst), .iow_i(iow), .ior_i(ior), .aen_i(aen), .sa_i(sa),
    .sd_in_i(sd_in), .sd_out_o(sd_out_a), .sd_oe_o(oe_a), .iocs16_oe_o(cs_a),
    .in_port_i(in_a), .out_reg_o(out_a), .wr_stb_o(stb_a)
  );

  isa_io_register_bank #(.DATA_W(16), .INVERT(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .iow_i(iow), .ior_i(ior), .aen_i(aen), .sa_i(sa),
    .sd_in_i(sd_in), .sd_out_o(sd_out_b), .sd_oe_o(oe_b), .iocs16_oe_o(cs_b),
    .in_port_i(in_b), .out_reg_o(out_b), .wr_stb_o(stb_b)
  );

`ifdef ISA_WDOG_EN
  logic [15:0] sd_out_c;
  logic        oe_c, cs_c;
  logic [31:0] out_c;
  logic [3:0]  stb_c;
  logic [15:0] smp_c;

  isa_io_register_bank #(.WDOG_CYCLES(24'd1000)) u_c (
    .clk_i(clk), .rst_i(rst), .iow_i(iow), .ior_i(ior), .aen_i(aen), .sa_i(sa),
    .sd_in_i(sd_in), .sd_out_o(sd_out_c), .sd_oe_o(oe_c), .iocs16_oe_o(cs_c),
    .in_port_i(in_a), .out_reg_o(out_c), .wr_stb_o(stb_c)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe activity monitor: cumulative pulse cycles and last non-zero pattern.
  int         stb_cyc_a = 0, stb_cyc_b = 0;
  logic [3:0] stb_last_a = '0, stb_last_b = '0;
  always @(negedge clk) begin
    if (stb_a != 4'b0) begin stb_cyc_a++; stb_last_a = stb_a; end
    if (stb_b != 4'b0) begin stb_cyc_b++; stb_last_b = stb_b; end
  end

  // Reference model: the bus value last written to each register.
  logic [15:0] mw [4];

  function automatic logic [31:0] exp_a();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = ~mw[i][7:0];
    return r;
  endfunction

  function automatic logic [63:0] exp_b();
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = mw[i];
    return r;
  endfunction

  function automatic logic is_reg(input logic [11:0] a, input logic ae);
    return !ae && a >= 12'h240 && a <= 12'h243;
  endfunction

  function automatic logic is_decoded(input logic [11:0] a, input logic ae);
`ifdef ISA_WDOG_EN
    return !ae && a >= 12'h240 && a <= 12'h245;
`else
    return !ae && a >= 12'h240 && a <= 12'h244;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [15:0] d, input logic ae,
                          input int low, input string tag);
    int          c0a, c0b;
    logic        hit;
    logic [31:0] olda;
    logic [63:0] oldb;
    hit  = is_reg(a, ae);
    olda = exp_a();
    oldb = exp_b();
    c0a  = stb_cyc_a;
    c0b  = stb_cyc_b;
    @(posedge clk); #1 sa = a; sd_in = d; aen = ae;
    @(posedge clk); #1 iow = 1'b0;
    @(negedge clk);
    chk({tag, " cs16_b"}, cs_b, is_decoded(a, ae));
    chk({tag, " cs16_a"}, cs_a, 1'b0);
    repeat (low) @(posedge clk);
    #1 iow = 1'b1;
    if (hit) mw[int'(a - 12'h240)] = d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, " out_a early"}, out_a, olda);
    chk({tag, " out_b early"}, out_b, oldb);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " out_a"}, out_a, exp_a());
    chk({tag, " out_b"}, out_b, exp_b());
    repeat (2) @(posedge clk);
    chk({tag, " stb_a count"}, stb_cyc_a - c0a, hit ? 1 : 0);
    chk({tag, " stb_b count"}, stb_cyc_b - c0b, hit ? 1 : 0);
    if (hit) begin
      chk({tag, " stb_a bit"}, stb_last_a, 4'b0001 << (a - 12'h240));
      chk({tag, " stb_b bit"}, stb_last_b, 4'b0001 << (a - 12'h240));
    end
    #1 sa = 12'h000; aen = 1'b0; sd_in = 16'h0000;
  endtask

  task automatic do_read(input logic [11:0] a, input logic ae, input logic [15:0] inp,
                         input logic e_oe, input logic [15:0] e_da, input logic [15:0] e_db,
                         input string tag);
    @(posedge clk); #1 sa = a; aen = ae; in_a = inp[7:0]; in_b = inp;
    @(posedge clk); #1 ior = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk({tag, " oe_a"}, oe_a, e_oe);
    chk({tag, " oe_b"}, oe_b, e_oe);
    chk({tag, " cs16_b"}, cs_b, is_decoded(a, ae));
    if (e_oe) begin
      chk({tag, " sd_a"}, sd_out_a, e_da);
      chk({tag, " sd_b"}, sd_out_b, e_db);
    end
`ifdef ISA_WDOG_EN
    smp_c = oe_c ? sd_out_c : 16'hDEAD;
`endif
    @(posedge clk); #1 ior = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, " oe_a released"}, oe_a, 1'b0);
    #1 sa = 12'h000; aen = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    logic [11:0] addr;
    logic [15:0] data;
    logic        ae;
    logic        e_oe;
    logic [15:0] e_da;
    logic [15:0] e_db;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        seen_oe;
    int          c0a;
    logic [11:0] ra;
    logic        rae;
    logic [15:0] rd;
    logic        r_oe;
    logic [15:0] r_da, r_db;

    tbl[0]  = '{0, 12'h241, 16'h00A5, 0, 0, 16'h0000, 16'h0000};
    tbl[1]  = '{1, 12'h241, 16'h0000, 0, 1, 16'h00A5, 16'h00A5};
    tbl[2]  = '{1, 12'h244, 16'hC33C, 0, 1, 16'h003C, 16'hC33C};
    tbl[3]  = '{0, 12'h243, 16'hBEEF, 0, 0, 16'h0000, 16'h0000};
    tbl[4]  = '{1, 12'h243, 16'h0000, 0, 1, 16'h00EF, 16'hBEEF};
    tbl[5]  = '{0, 12'h240, 16'h0011, 1, 0, 16'h0000, 16'h0000};
    tbl[6]  = '{0, 12'h250, 16'h0022, 0, 0, 16'h0000, 16'h0000};
    tbl[7]  = '{1, 12'h240, 16'h0000, 0, 1, 16'h0000, 16'h0000};
    tbl[8]  = '{1, 12'h250, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    tbl[9]  = '{0, 12'h245, 16'h0033, 0, 0, 16'h0000, 16'h0000};
`ifdef ISA_WDOG_EN
    tbl[10] = '{1, 12'h245, 16'h0000, 0, 1, 16'h0000, 16'h0000};
`else
    tbl[10] = '{1, 12'h245, 16'h0000, 0, 0, 16'h0000, 16'h0000};
`endif
    tbl[11] = '{1, 12'h244, 16'h5A5A, 1, 0, 16'h0000, 16'h0000};
    tbl[12] = '{0, 12'h244, 16'h0044, 0, 0, 16'h0000, 16'h0000};

    for (int i = 0; i < 4; i++) mw[i] = 16'h0000;
    rst = 1'b1; iow = 1'b1; ior = 1'b1; aen = 1'b0;
    sa = 12'h000; sd_in = 16'h0000; in_a = 8'h00; in_b = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_a", out_a, 32'hFFFF_FFFF);
    chk("reset out_b", out_b, 64'h0);
    chk("reset stb", {stb_a, stb_b}, 8'h00);
    chk("reset oe", {oe_a, oe_b}, 2'b00);
    chk("reset sd_out", {sd_out_a, sd_out_b}, 32'h0);
    chk("reset cs16", {cs_a, cs_b}, 2'b00);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rd)
        do_read(tbl[i].addr, tbl[i].ae, tbl[i].data, tbl[i].e_oe, tbl[i].e_da, tbl[i].e_db,
                $sformatf("vec%0d rd", i));
      else
        do_write(tbl[i].addr, tbl[i].data, tbl[i].ae, 20, $sformatf("vec%0d wr", i));
    end

    // IOR and IOW low together: write commits, bus never driven.
    @(posedge clk); #1 sa = 12'h240; sd_in = 16'h0077; aen = 1'b0;
    @(posedge clk); #1 iow = 1'b0; ior = 1'b0;
    seen_oe = 1'b0;
    c0a = stb_cyc_a;
    repeat (10) begin
      @(negedge clk);
      seen_oe = seen_oe | oe_a | oe_b;
    end
    @(posedge clk); #1 iow = 1'b1; ior = 1'b1;
    mw[0] = 16'h0077;
    repeat (4) begin
      @(negedge clk);
      seen_oe = seen_oe | oe_a | oe_b;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("both low oe", seen_oe, 1'b0);
    chk("both low out_a", out_a, exp_a());
    chk("both low out_b", out_b, exp_b());
    chk("both low stb", stb_cyc_a - c0a, 1);
    #1 sa = 12'h000; sd_in = 16'h0000;

    // Reset while IOW low mid-write; the still-low strobe must not commit.
    @(posedge clk); #1 sa = 12'h242; sd_in = 16'h1234;
    @(posedge clk); #1 iow = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) mw[i] = 16'h0000;
    @(negedge clk);
    chk("rst mid-write out_a", out_a, 32'hFFFF_FFFF);
    chk("rst mid-write out_b", out_b, 64'h0);
    c0a = stb_cyc_a;
    repeat (8) @(posedge clk);
    #1 iow = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rst no commit stb", stb_cyc_a - c0a, 0);
    chk("rst no commit out_a", out_a, exp_a());
    chk("rst no commit out_b", out_b, exp_b());
    #1 sa = 12'h000; sd_in = 16'h0000;

    // Randomised traffic against the model.
    for (int n = 0; n < 40; n++) begin
      ra  = 12'h23E + 12'($urandom_range(0, 8));
      rae = ($urandom_range(0, 7) == 0);
      rd  = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(ra, rd, rae, $urandom_range(4, 12), $sformatf("rnd%0d wr", n));
      end else begin
        r_oe = is_decoded(ra, rae);
        r_da = 16'h0000;
        r_db = 16'h0000;
        if (is_reg(ra, rae)) begin
          r_da = {8'h00, mw[int'(ra - 12'h240)][7:0]};
          r_db = mw[int'(ra - 12'h240)];
        end else if (ra == 12'h244) begin
          r_da = {8'h00, rd[7:0]};
          r_db = rd;
        end
        do_read(ra, rae, rd, r_oe, r_da, r_db, $sformatf("rnd%0d rd", n));
      end
    end

`ifdef ISA_WDOG_EN
    do_write(12'h241, 16'h00A5, 1'b0, 8, "wdog wr1");
    do_write(12'h240, 16'h0000, 1'b0, 8, "wdog wr0");
    chk("wdog reg1 before", out_c[15:8], 8'h5A);
    do_read(12'h245, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, "wdog rd clear");
    chk("wdog flag clear", smp_c, 16'h0000);
    repeat (1010) @(posedge clk);
    @(negedge clk);
    chk("wdog trip out_c", out_c, 32'hFFFF_FFFF);
    do_read(12'h245, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, "wdog rd trip");
    chk("wdog flag set", smp_c, 16'h0001);
    do_write(12'h242, 16'h0055, 1'b0, 8, "wdog wr2");
    chk("wdog reg2 after", out_c[23:16], 8'hAA);
    do_read(12'h245, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, "wdog rd reclr");
    chk("wdog flag recleared", smp_c, 16'h0000);
`endif

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
